// File: rtl/otter_alu_pkg.sv
// Shared encodings for the OTTER multicycle ALU: base-op codes, RV32M func3
// values, OP field positions and the control state type.
package otter_alu_pkg;

  localparam int OP_M_BIT   = 4;
  localparam int OP_SEL_MSB = 3;
  localparam int OP_F3_MSB  = 2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SUB  = 4'd8;
  localparam logic [3:0] ALU_LUI  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd13;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } alu_state_e;

endpackage

// File: rtl/otter_alu_comb.sv
// Single-cycle RV32I base ALU; purely combinational, unknown codes give zero.
module otter_alu_comb
  import otter_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       sel_i,
  output logic [WIDTH-1:0] y_o
);

  logic [SHAMT_W-1:0] shamt_s;
  assign shamt_s = b_i[SHAMT_W-1:0];

  // Base operation select
  always_comb begin
    y_o = '0;
    case (sel_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> shamt_s;
      ALU_SLL:  y_o = a_i << shamt_s;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt_s);
      ALU_SLT:  y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: y_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_LUI:  y_o = a_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/otter_alu_mc.sv
// Multicycle OTTER ALU: 1-cycle base ops, iterative shift-add multiply and
// restoring divide sharing one counter and one 2*WIDTH accumulator.
module otter_alu_mc
  import otter_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             KILL,
  input  logic [4:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHAMT_W-1:0] CNT_INIT = SHAMT_W'(WIDTH-1);
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  alu_state_e           state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH:0]       opb_q, opb_d;
  logic [2:0]           f3_q, f3_d;
  logic                 neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 m_s, div_signed_s, is_rem_s, b_zero_s, div_ovf_s, a_neg_s, b_neg_s;
  logic [OP_F3_MSB:0]   f3_s;
  logic [OP_SEL_MSB:0]  sel_s;
  logic [WIDTH-1:0]     base_y_s, fast_y_s, a_mag_s, b_mag_s;
  logic [WIDTH:0]       mul_a_ext_s, mul_b_ext_s, div_hi_s;
  logic [2*WIDTH-1:0]   mul_add_s, mul_sub_s, mul_acc_s, div_acc_s;
  logic [WIDTH-1:0]     div_diff_s, div_q_s, div_r_s, mul_y_s, div_y_s;
  logic                 div_ge_s;

  assign m_s   = OP[OP_M_BIT];
  assign f3_s  = OP[OP_F3_MSB:0];
  assign sel_s = OP[OP_SEL_MSB:0];

  otter_alu_comb #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_comb (
    .a_i   (A),
    .b_i   (B),
    .sel_i (sel_s),
    .y_o   (base_y_s)
  );

  // Divide set-up at accept: sign handling, magnitudes and the 1-cycle cases
  assign div_signed_s = (f3_s == M_DIV) || (f3_s == M_REM);
  assign is_rem_s     = (f3_s == M_REM) || (f3_s == M_REMU);
  assign b_zero_s     = (B == '0);
  assign div_ovf_s    = div_signed_s && (A == MIN_NEG) && (B == '1);
  assign a_neg_s      = div_signed_s && A[WIDTH-1];
  assign b_neg_s      = div_signed_s && B[WIDTH-1];
  assign a_mag_s      = a_neg_s ? (~A + ONE_W) : A;
  assign b_mag_s      = b_neg_s ? (~B + ONE_W) : B;
  assign fast_y_s     = is_rem_s ? (b_zero_s ? A : '0) : (b_zero_s ? '1 : A);

  assign mul_a_ext_s = {(f3_s != M_MULHU) & A[WIDTH-1], A};
  assign mul_b_ext_s = {((f3_s == M_MUL) || (f3_s == M_MULH)) & B[WIDTH-1], B};

  // Multiplier sign bit weighs -2^WIDTH, so it is subtracted on the last step
  assign mul_add_s = opb_q[0] ? mcand_q : '0;
  assign mul_sub_s = ((cnt_q == '0) && opb_q[1]) ? {mcand_q[2*WIDTH-2:0], 1'b0} : '0;
  assign mul_acc_s = acc_q + mul_add_s - mul_sub_s;
  assign mul_y_s   = (f3_q == M_MUL) ? mul_acc_s[WIDTH-1:0] : mul_acc_s[2*WIDTH-1:WIDTH];

  assign div_hi_s   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge_s   = (div_hi_s >= opb_q);
  assign div_diff_s = WIDTH'(div_hi_s - opb_q);
  assign div_acc_s  = {div_ge_s ? div_diff_s : div_hi_s[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge_s};
  assign div_q_s    = div_acc_s[WIDTH-1:0];
  assign div_r_s    = div_acc_s[2*WIDTH-1:WIDTH];
  assign div_y_s    = ((f3_q == M_REM) || (f3_q == M_REMU)) ?
                      (neg_r_q ? (~div_r_s + ONE_W) : div_r_s) :
                      (neg_q_q ? (~div_q_s + ONE_W) : div_q_s);

  // Control and datapath next state; RESULT/DONE are loaded on entry to FIN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (KILL) begin
          state_d = S_IDLE;
        end else if (START) begin
          busy_d = 1'b1;
          f3_d   = f3_s;
          cnt_d  = CNT_INIT;
          if (!m_s) begin
            state_d  = S_FIN;
            result_d = base_y_s;
            done_d   = 1'b1;
          end else if (!f3_s[2]) begin
            state_d = S_MUL;
            acc_d   = '0;
            mcand_d = {{(WIDTH-1){mul_a_ext_s[WIDTH]}}, mul_a_ext_s};
            opb_d   = mul_b_ext_s;
          end else if (b_zero_s || div_ovf_s) begin
            state_d  = S_FIN;
            result_d = fast_y_s;
            done_d   = 1'b1;
          end else begin
            state_d = S_DIV;
            acc_d   = {{WIDTH{1'b0}}, a_mag_s};
            opb_d   = {1'b0, b_mag_s};
            neg_q_d = a_neg_s ^ b_neg_s;
            neg_r_d = a_neg_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (KILL) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d   = mul_acc_s;
          mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
          opb_d   = {1'b0, opb_q[WIDTH:1]};
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == '0) begin
            state_d  = S_FIN;
            result_d = mul_y_s;
            done_d   = 1'b1;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_DIV: begin
        if (KILL) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = div_acc_s;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == '0) begin
            state_d  = S_FIN;
            result_d = div_y_s;
            done_d   = 1'b1;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      // DONE and RESULT are already visible here, so KILL has nothing left to cancel
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      f3_q     <= 3'd0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign RESULT = result_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_otter_alu_mc.sv
// Scoreboard bench for otter_alu_mc: a driver queues expected results and DONE
// cycles from an arithmetic reference model; a monitor checks every DONE.
`timescale 1ns/1ps
module tb_otter_alu_mc;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST_N, START, KILL;
  logic [4:0]   OP;
  logic [W-1:0] A, B, RESULT;
  logic         BUSY, DONE;

  otter_alu_mc #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .KILL(KILL), .OP(OP),
    .A(A), .B(B), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
    logic [4:0]   op;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] last_res = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model written from the instruction semantics
  function automatic logic [W-1:0] ref_res(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p, xa, xb;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (!op[4]) begin
      case (op[3:0])
        4'd0:    return a + b;
        4'd8:    return a - b;
        4'd6:    return a | b;
        4'd7:    return a & b;
        4'd4:    return a ^ b;
        4'd5:    return a >> b[4:0];
        4'd1:    return a << b[4:0];
        4'd13:   return $unsigned(sa >>> b[4:0]);
        4'd2:    return (sa < sb) ? 32'd1 : 32'd0;
        4'd3:    return (a < b) ? 32'd1 : 32'd0;
        4'd9:    return a;
        default: return 32'd0;
      endcase
    end
    xa = (op[2:0] == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
    xb = (op[2:0] <= 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = xa * xb;
    case (op[2:0])
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $unsigned(sa / sb);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $unsigned(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic sgn;
    if (!op[4]) return 1;
    if (!op[2]) return W + 1;
    sgn = !op[0];
    if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return W + 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every DONE must match the oldest outstanding expectation
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N === 1'b1 && DONE === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: DONE=1 at cycle %0d with nothing outstanding, required 0", cyc);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("result op=%0h", e.op), RESULT, e.res);
        chk($sformatf("done_cycle op=%0h", e.op), 32'(cyc), 32'(e.cyc));
        last_res = e.res;
      end
    end
  end

  // Drive one START for a single cycle, called at a negedge while idle
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_done);
    exp_t e;
    START = 1'b1;
    OP    = op;
    A     = a;
    B     = b;
    if (expect_done) begin
      e.res = ref_res(op, a, b);
      e.cyc = cyc + ref_lat(op, a, b);
      e.op  = op;
      sb_q.push_back(e);
    end
    @(negedge CLK);
    START = 1'b0;
    A     = 32'($urandom);
    B     = 32'($urandom);
    OP    = 5'($urandom);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (BUSY && g < 100) begin
      @(negedge CLK);
      g++;
    end
    chk("idle_within_bound", {31'd0, BUSY}, 32'd0);
  endtask

  logic [4:0]   d_op[15] = '{5'd8, 5'd13, 5'd3, 5'h11, 5'h12, 5'h10, 5'h14, 5'h16, 5'h15, 5'h17,
                             5'h14, 5'h17, 5'h14, 5'h16, 5'd0};
  logic [W-1:0] d_a[15]  = '{32'd5, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd123456,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000, 32'd3};
  logic [W-1:0] d_b[15]  = '{32'd7, 32'd4, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd654321,
                             32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    RST_N = 1'b0;
    START = 1'b0;
    KILL  = 1'b0;
    OP    = 5'd0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (3) @(negedge CLK);
    chk("reset_result", RESULT, 32'd0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_done", {31'd0, DONE}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Directed vectors, issued back-to-back as soon as BUSY drops
    for (int i = 0; i < 15; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 1'b1);
      wait_idle();
    end
    chk("held_result", RESULT, last_res);

    // Asynchronous reset in the middle of a multiply
    issue(5'h10, 32'd7, 32'd9, 1'b0);
    repeat (9) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("midmul_reset_busy", {31'd0, BUSY}, 32'd0);
    chk("midmul_reset_result", RESULT, 32'd0);
    last_res = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);
    chk("after_reset_idle", {31'd0, BUSY}, 32'd0);

    // START while busy must be ignored
    issue(5'h10, 32'd1234, 32'd5678, 1'b1);
    repeat (5) @(negedge CLK);
    START = 1'b1;
    OP    = 5'h15;
    A     = 32'd99;
    B     = 32'd3;
    @(negedge CLK);
    START = 1'b0;
    wait_idle();
    repeat (3) @(negedge CLK);
    chk("start_while_busy_held", RESULT, last_res);

    // KILL during a divide: no DONE, RESULT unchanged
    issue(5'h14, 32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge CLK);
    KILL = 1'b1;
    @(negedge CLK);
    KILL = 1'b0;
    chk("kill_busy", {31'd0, BUSY}, 32'd0);
    chk("kill_result", RESULT, last_res);
    repeat (40) @(negedge CLK);

    // KILL beats START in IDLE
    START = 1'b1;
    KILL  = 1'b1;
    OP    = 5'd0;
    A     = 32'd1;
    B     = 32'd2;
    @(negedge CLK);
    START = 1'b0;
    KILL  = 1'b0;
    chk("kill_idle_busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    chk("kill_idle_result", RESULT, last_res);

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) op = {1'b0, 4'($urandom_range(0, 15))};
      else                           op = {1'b1, 4'($urandom_range(0, 15))};
      issue(op, pick(), pick(), 1'b1);
      wait_idle();
    end

    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
